store_unit: RTL

- Multi-cycle store engine for RISC-V S-type instructions (sb/sh/sw/sd). It is the write-side counterpart to the load path.
- Accepts an instruction plus rs1/rs2 values and computes the effective address as rs1 + sign-extended S-immediate.
- Writes the data memory. Sub-doubleword stores use read-modify-write on the enclosing 64-bit doubleword.
- Sits between the register file read ports and the data memory, in the same datapath as the load path.

---
 rtl/store_unit.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/store_unit.sv
// Multi-cycle RISC-V S-type store engine (sb/sh/sw/sd).
// Sub-doubleword stores read-modify-write the enclosing 64-bit doubleword.
module store_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    WAIT_RD,
    MERGE,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] eff_q, eff_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [6:0]      opcode_q, opcode_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            mem_re_q, mem_re_d;

  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] eff_in;
  logic [XLEN-1:0] aligned_addr;
  logic            illegal;
  logic            misaligned;
  logic [7:0]      lane_mask;
  logic [XLEN-1:0] rs2_shifted;
  logic [XLEN-1:0] merged;

  // Register-index fields are not needed here; rs1/rs2 values arrive pre-read.
  logic            unused_inst_bits;
  assign unused_inst_bits = ^inst[24:15];

  assign imm_sext     = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign eff_in       = rs1_data + imm_sext;
  assign aligned_addr = {eff_q[XLEN-1:3], 3'b000};

  always_comb begin
    illegal    = (opcode_q != OPCODE_STORE) || funct3_q[2];
    misaligned = 1'b0;
    case (funct3_q[1:0])
      2'b01:   misaligned = eff_q[0];
      2'b10:   misaligned = |eff_q[1:0];
      2'b11:   misaligned = |eff_q[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Byte-lane merge of the store data into the doubleword just read back.
  always_comb begin
    lane_mask = 8'h00;
    case (funct3_q[1:0])
      2'b00:   lane_mask = 8'h01 << eff_q[2:0];
      2'b01:   lane_mask = 8'h03 << eff_q[2:0];
      default: lane_mask = 8'h0F << eff_q[2:0];
    endcase
    rs2_shifted = rs2_q << {eff_q[2:0], 3'b000};
    merged      = mem_rdata;
    for (int k = 0; k < 8; k++) begin
      if (lane_mask[k]) begin
        merged[8*k +: 8] = rs2_shifted[8*k +: 8];
      end
    end
  end

  // Each state computes its outputs here; they become visible one cycle
  // later through the output registers, which sets the overall latency.
  always_comb begin
    state_d     = state_q;
    eff_d       = eff_q;
    rs2_d       = rs2_q;
    funct3_d    = funct3_q;
    opcode_d    = opcode_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = '0;
    mem_addr_d  = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          eff_d    = eff_in;
          rs2_d    = rs2_data;
          funct3_d = inst[14:12];
          opcode_d = inst[6:0];
          state_d  = DECODE;
        end
      end
      DECODE: begin
        if (illegal || misaligned) begin
          state_d = ERR;
        end else if (funct3_q[1:0] == 2'b11) begin
          state_d = WRITE;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        mem_re_d   = 1'b1;
        mem_addr_d = aligned_addr;
        state_d    = WAIT_RD;
      end
      WAIT_RD: begin
        state_d = MERGE;
      end
      MERGE: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = aligned_addr;
        mem_wdata_d = merged;
        state_d     = DONE;
      end
      WRITE: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = aligned_addr;
        mem_wdata_d = rs2_q;
        state_d     = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Busy stays up through the done cycle so a start there is refused.
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      eff_q       <= '0;
      rs2_q       <= '0;
      funct3_q    <= '0;
      opcode_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      eff_q       <= eff_d;
      rs2_q       <= rs2_d;
      funct3_q    <= funct3_d;
      opcode_q    <= opcode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule
